// File: rtl/de2_status_monitor_if.sv
// Signal bundle between the board wrapper and de2_status_monitor.
// The wrapper side uses the master modport; the monitor uses slave.
interface de2_status_monitor_if #(
  parameter int NUM_CH = 2
);
  logic                LOCKUP;
  logic [NUM_CH-1:0]   DataValid;
  logic                ClearErr;
  logic                SysResetn;
  logic                Heartbeat;
  logic                ErrorAny;
  logic [2*NUM_CH-1:0] Status;
  logic [7*NUM_CH-1:0] HEX;

  modport master (
    output LOCKUP, DataValid, ClearErr,
    input  SysResetn, Heartbeat, ErrorAny, Status, HEX
  );

  modport slave (
    input  LOCKUP, DataValid, ClearErr,
    output SysResetn, Heartbeat, ErrorAny, Status, HEX
  );
endinterface

// File: rtl/de2_status_monitor.sv
// Multi-channel board status monitor: per-channel DataValid watchdogs, sticky lockup flag,
// seven-segment status digits and a synchronised reset. Optional macro: STATUS_BLINK_EN.
module de2_status_monitor #(
  parameter int NUM_CH          = 2,
  parameter int HB_MSB          = 25,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int RST_SYNC_STAGES = 2
) (
  input  logic                CLOCK_50,
  input  logic                HRESETn,
  de2_status_monitor_if.slave mon
);

  localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);
  localparam logic [HB_MSB:0] TC_ONE = (HB_MSB + 1)'(1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_INVALID = 2'd1,
    ST_STALL   = 2'd2,
    ST_LOCKED  = 2'd3
  } status_e;

  localparam logic [6:0] SEG_L   = ~7'b0111000;
  localparam logic [6:0] SEG_S   = ~7'b1101101;
  localparam logic [6:0] SEG_E   = ~7'b1111001;
  localparam logic [6:0] SEG_O   = ~7'b1011100;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [HB_MSB:0]            tc_q;
  logic                       hb_q, hb_d;
  logic [WD_W-1:0]            wd_q [NUM_CH];
  logic [WD_W-1:0]            wd_d [NUM_CH];
  logic [NUM_CH-1:0]          stall_q, stall_d;
  logic                       lock_q, lock_d;
  logic [2:0]                 clr_sync_q;
  logic                       clr;
  logic                       err_vis;
  logic [2*NUM_CH-1:0]        status_q, status_d;
  logic [7*NUM_CH-1:0]        hex_q, hex_d;
  logic                       err_q;
  logic [RST_SYNC_STAGES-1:0] rst_sr_q;
  status_e                    ch_st;

  always_comb begin
    hb_d     = tc_q[HB_MSB] & tc_q[HB_MSB-2];
`ifdef STATUS_BLINK_EN
    err_vis  = tc_q[HB_MSB-1];
`else
    err_vis  = 1'b1;
`endif
    // clr is a one-cycle pulse on the synchronised rising edge of ClearErr.
    clr      = clr_sync_q[1] & ~clr_sync_q[2];
    lock_d   = mon.LOCKUP | (lock_q & ~clr);
    stall_d  = '0;
    status_d = '0;
    hex_d    = '1;
    ch_st    = ST_RUN;
    for (int i = 0; i < NUM_CH; i++) begin
      wd_d[i] = wd_q[i];
      if (mon.DataValid[i]) begin
        wd_d[i] = '0;
      end else if (wd_q[i] != WD_MAX) begin
        wd_d[i] = wd_q[i] + WD_ONE;
      end
      // The set term only fires on the edge that takes the counter to the limit,
      // so a saturated counter cannot re-flag a stall after a clear.
      stall_d[i] = (~mon.DataValid[i] & (wd_q[i] == (WD_MAX - WD_ONE)))
                 | (stall_q[i] & ~clr);

      if (lock_q) begin
        ch_st = ST_LOCKED;
      end else if (stall_q[i]) begin
        ch_st = ST_STALL;
      end else if (!mon.DataValid[i]) begin
        ch_st = ST_INVALID;
      end else begin
        ch_st = ST_RUN;
      end
      status_d[2*i +: 2] = ch_st;

      case (ch_st)
        ST_LOCKED:  hex_d[7*i +: 7] = err_vis ? SEG_L : SEG_OFF;
        ST_STALL:   hex_d[7*i +: 7] = err_vis ? SEG_S : SEG_OFF;
        ST_INVALID: hex_d[7*i +: 7] = err_vis ? SEG_E : SEG_OFF;
        default:    hex_d[7*i +: 7] = hb_d ? SEG_O : SEG_OFF;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      tc_q       <= '0;
      hb_q       <= 1'b0;
      stall_q    <= '0;
      lock_q     <= 1'b0;
      clr_sync_q <= '0;
      status_q   <= '0;
      hex_q      <= '1;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        wd_q[i] <= '0;
      end
    end else begin
      tc_q       <= tc_q + TC_ONE;
      hb_q       <= hb_d;
      stall_q    <= stall_d;
      lock_q     <= lock_d;
      clr_sync_q <= {clr_sync_q[1:0], mon.ClearErr};
      status_q   <= status_d;
      hex_q      <= hex_d;
      err_q      <= lock_q | (|stall_q);
      for (int i = 0; i < NUM_CH; i++) begin
        wd_q[i] <= wd_d[i];
      end
    end
  end

  // Downstream reset: asserted asynchronously, released after RST_SYNC_STAGES clean edges.
  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      rst_sr_q <= '0;
    end else begin
      rst_sr_q <= {rst_sr_q[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign mon.SysResetn = rst_sr_q[RST_SYNC_STAGES-1];
  assign mon.Heartbeat = hb_q;
  assign mon.ErrorAny  = err_q;
  assign mon.Status    = status_q;
  assign mon.HEX       = hex_q;

endmodule
